// File: rtl/fsm_pkg.sv
// Shared definitions for the controller/worker pair: state encoding and default operand width.
package fsm_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/seq_mult_worker_if.sv
// Launch/operand/result bundle between a job source (master) and the multiply worker (slave).
interface seq_mult_worker_if
  import fsm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  // Handshake: launch is a request honoured only while the worker is idle; no ready is
  // returned, the source must watch active/done. done is a one-cycle pulse and product
  // is valid from that cycle until the next completion.
  logic               launch;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               active;
  logic               done;
  logic [2*WIDTH-1:0] product;
  state_t             state;

  modport master (output launch, op_a, op_b, input active, done, product, state);
  modport slave  (input launch, op_a, op_b, output active, done, product, state);
endinterface

// File: rtl/seq_mult_datapath.sv
// Shift-add multiply datapath: load captures operands, each step consumes one multiplier bit.
module seq_mult_datapath
  import fsm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] acc_o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CW-1:0]      cnt_q;

  // acc_o includes the current step's add so the final result can be taken on the last edge.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  assign acc_o  = acc_d;
  assign last_o = (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, op_a_i};
      mplier_q <= op_b_i;
      acc_q    <= '0;
      cnt_q    <= CW'(WIDTH);
    end else if (step_i) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end
endmodule

// File: rtl/seq_mult_worker.sv
// Fixed-latency sequential unsigned multiplier: IDLE -> RUN (WIDTH cycles) -> DONE -> IDLE.
module seq_mult_worker
  import fsm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               reset,
  seq_mult_worker_if.slave  bus
);
  state_t             state_q;
  logic               active_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;
  logic               load;
  logic               step;
  logic               last;
  logic [2*WIDTH-1:0] acc;

  assign load = (state_q == IDLE) && bus.launch;
  assign step = (state_q == RUN);

  seq_mult_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .step_i (step),
    .op_a_i (bus.op_a),
    .op_b_i (bus.op_b),
    .last_o (last),
    .acc_o  (acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.launch) begin
            state_q  <= RUN;
            active_q <= 1'b1;
          end
        end
        RUN: begin
          if (last) begin
            product_q <= acc;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q   <= 1'b0;
          active_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          active_q  <= 1'b0;
          done_q    <= 1'b0;
          product_q <= '0;
        end
      endcase
    end
  end

  assign bus.active  = active_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.state   = state_q;
endmodule

// File: tb/tb_seq_mult_worker.sv
// Directed bench for seq_mult_worker at WIDTH=8: vector table plus corner-case sequences.
module tb_seq_mult_worker;
  import fsm_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_p;

  seq_mult_worker_if #(.WIDTH(W)) bus ();

  seq_mult_worker #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one job and check the full timing: done exactly WIDTH edges after E0.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] prod, input string name);
    exp_q.push_back(prod);
    bus.launch = 1'b1;
    bus.op_a   = a;
    bus.op_b   = b;
    tick();
    bus.launch = 1'b0;
    bus.op_a   = W'($urandom_range(0, 255));
    bus.op_b   = W'($urandom_range(0, 255));
    check({name, " active_after_launch"}, 32'(bus.active), 32'd1);
    check({name, " done_low_at_launch"}, 32'(bus.done), 32'd0);
    for (int k = 1; k <= W; k++) begin
      tick();
      if (k < W) begin
        if (bus.done !== 1'b0) check({name, " early_done"}, 32'(bus.done), 32'd0);
      end else begin
        exp_p = exp_q.pop_front();
        check({name, " done_at_edge_W"}, 32'(bus.done), 32'd1);
        check({name, " product"}, 32'(bus.product), 32'(exp_p));
      end
    end
    tick();
    check({name, " done_one_cycle"}, 32'(bus.done), 32'd0);
    check({name, " active_drop"}, 32'(bus.active), 32'd0);
    check({name, " product_hold"}, 32'(bus.product), 32'(exp_p));
  endtask

  vec_t vecs[7];
  int done_seen;

  initial begin
    vecs[0] = '{a: 8'd13,  b: 8'd11,  prod: 16'd143};
    vecs[1] = '{a: 8'd255, b: 8'd255, prod: 16'd65025};
    vecs[2] = '{a: 8'd0,   b: 8'd200, prod: 16'd0};
    vecs[3] = '{a: 8'd200, b: 8'd0,   prod: 16'd0};
    vecs[4] = '{a: 8'd1,   b: 8'd1,   prod: 16'd1};
    vecs[5] = '{a: 8'd128, b: 8'd2,   prod: 16'd256};
    vecs[6] = '{a: 8'd170, b: 8'd85,  prod: 16'd14450};

    bus.launch = 1'b0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    reset      = 1'b1;
    tick();
    tick();
    check("reset active", 32'(bus.active), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset product", 32'(bus.product), 32'd0);
    check("reset state", 32'(bus.state), 32'(IDLE));
    reset = 1'b0;
    tick();
    check("idle hold state", 32'(bus.state), 32'(IDLE));

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i));
      tick();
    end

    // Second launch during RUN must be ignored.
    bus.launch = 1'b1;
    bus.op_a   = 8'd7;
    bus.op_b   = 8'd9;
    tick();
    bus.launch = 1'b0;
    done_seen  = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        bus.launch = 1'b1;
        bus.op_a   = 8'd100;
        bus.op_b   = 8'd100;
      end else begin
        bus.launch = 1'b0;
      end
      tick();
      if (bus.done) done_seen++;
      if (k == W) begin
        check("ignored done_at_8", 32'(bus.done), 32'd1);
        check("ignored product", 32'(bus.product), 32'd63);
      end
    end
    bus.launch = 1'b0;
    check("ignored single_done", 32'(done_seen), 32'd1);
    check("ignored product_hold", 32'(bus.product), 32'd63);

    // Reset mid-run clears everything and suppresses done.
    bus.launch = 1'b1;
    bus.op_a   = 8'd20;
    bus.op_b   = 8'd30;
    tick();
    bus.launch = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset active", 32'(bus.active), 32'd0);
    check("midreset product", 32'(bus.product), 32'd0);
    check("midreset done", 32'(bus.done), 32'd0);
    check("midreset state", 32'(bus.state), 32'(IDLE));
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.done) done_seen++;
    end
    check("midreset no_done", 32'(done_seen), 32'd0);
    run_job(8'd5, 8'd6, 16'd30, "after_reset");
    tick();

    // Launch held high: jobs back-to-back at period WIDTH+2.
    bus.launch = 1'b1;
    bus.op_a   = 8'd3;
    bus.op_b   = 8'd4;
    for (int c = 0; c < 25; c++) begin
      tick();
      check($sformatf("b2b done c%0d", c), 32'(bus.done), 32'((c % 10) == 8));
      if ((c % 10) == 8) check($sformatf("b2b product c%0d", c), 32'(bus.product), 32'd12);
    end
    bus.launch = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    check("b2b final_idle", 32'(bus.state), 32'(IDLE));
    check("b2b final_product", 32'(bus.product), 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
